serializador: RTL and testbench
===============================

SERIALIZADOR -- requirements
Module: serializador

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the parallel word width in bits; legal range 2..32.
REQ-002 The block SHALL have port clock_100KHz  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port data_in  input  DATA_W  parallel word to transmit.
REQ-005 The block SHALL have port load_in  input  1  producer requests transmission of data_in.
REQ-006 The block SHALL have port ack_out  output  1  one-cycle pulse: data_in captured, producer may advance.
REQ-007 The block SHALL have port status_out  output  1  high = IDLE and able to accept a word.
REQ-008 The block SHALL have port status_in  input  1  receiver ready (driven by the deserializer's status output).
REQ-009 The block SHALL have port data_out  output  1  serial bit, LSB first.
REQ-010 The block SHALL have port write_out  output  1  high = data_out carries a valid bit for the receiver.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, SHIFT and DONE, plus PARITY when configured (REQ-026).
REQ-012 In IDLE, when load_in=1 and status_in=1 at a rising edge, the block SHALL capture data_in into a shift register. On that same edge it SHALL set ack_out=1, status_out=0, write_out=1, data_out=data_in[0] and bit counter=1, and SHALL go to SHIFT.
REQ-013 In IDLE, when load_in=1 and status_in=0, the block SHALL stay in IDLE, SHALL keep ack_out=0 and SHALL NOT capture data_in.
REQ-014 ack_out SHALL be high for exactly one cycle per accepted word.
REQ-015 In SHIFT, each edge SHALL drive data_out=word[counter] and increment the counter while counter<DATA_W. The counter SHALL be $clog2(DATA_W+1) bits wide.
REQ-016 In SHIFT, the edge where counter=DATA_W SHALL end the data phase: go to PARITY if configured, otherwise go to DONE with write_out=0 and data_out=0.
REQ-017 write_out SHALL be high for exactly DATA_W consecutive cycles per word (DATA_W+1 with parity). Bit i SHALL be on data_out during the (i+1)-th high cycle, and write_out SHALL have no gaps within a frame.
REQ-018 load_in SHALL be ignored in SHIFT, PARITY and DONE: no capture and no ack_out.
REQ-019 A drop of status_in during SHIFT or PARITY SHALL NOT pause or abort the frame.
REQ-020 DONE SHALL last at least one cycle. At the first edge in DONE where status_in=1, the block SHALL go to IDLE and set status_out=1.
REQ-021 Back-to-back words SHALL therefore need at least DATA_W+2 cycles apart (DATA_W+3 with parity).
REQ-022 All outputs SHALL be registered, with no combinational path from an input to an output.

Reset
REQ-023 When reset=0, the block SHALL immediately force IDLE, counter=0, shift register=0, data_out=0, write_out=0 and ack_out=0. status_out SHALL become 1 at the first rising edge after reset is released.
REQ-024 While reset=0, status_out SHALL be 0.
REQ-025 A reset during SHIFT, PARITY or DONE SHALL abort the frame. No partial word SHALL be resumed, and the producer SHALL re-present the word.

Configuration
REQ-026 With macro SERIALIZADOR_PARITY_EN defined, the block SHALL include state PARITY. After the last data bit it SHALL hold write_out=1 for one extra cycle with data_out = XOR of all DATA_W captured bits (even parity), then go to DONE with write_out=0.
REQ-027 Without SERIALIZADOR_PARITY_EN, the block SHALL contain no PARITY state or parity logic, and frames SHALL be exactly DATA_W bits.

Verification
REQ-028 Basic frame, DATA_W=8, no parity. Stimulus: status_in=1, load_in pulsed with data_in=8'hA5. Required: ack_out high 1 cycle; write_out high 8 cycles; data_out sequence 1,0,1,0,0,1,0,1; status_out returns to 1 two cycles after the last bit.
REQ-029 Receiver busy. Stimulus: status_in=0, load_in=1 with 8'h3C held for 5 cycles, then status_in=1. Required: no ack_out and write_out=0 for those 5 cycles; ack_out on the first edge with status_in=1; 3C shifted out as 0,0,1,1,1,1,0,0.
REQ-030 Load while busy. Stimulus: 8'hFF accepted, then load_in=1 with 8'h00 during SHIFT. Required: only one ack_out; all 8 bits out are 1; 8'h00 is accepted only after IDLE is re-entered.
REQ-031 Reset mid-frame. Stimulus: reset=0 asserted after bit 3 of 8'h81. Required: write_out, data_out and ack_out go to 0 asynchronously; status_out=1 one edge after release; the next frame starts from bit 0.
REQ-032 Parity. Stimulus: SERIALIZADOR_PARITY_EN defined, send 8'h07 then 8'h03. Required: 9 write_out cycles each; parity bit 1 for 8'h07 and 0 for 8'h03.
REQ-033 Back-to-back frames. Stimulus: status_in tied to 1, load_in tied to 1, data_in=8'h55. Required: ack_out period = 10 cycles (no parity); write_out low for exactly 2 cycles between frames.

Source files
------------

// File: rtl/serializador.sv
// Parallel-to-serial transmitter: LSB-first frame with write strobe and
// ready/ack handshakes. Optional even parity bit: SERIALIZADOR_PARITY_EN.
//
// Ports:
//   clock_100KHz : clock, rising edge
//   reset        : async active-low reset
//   data_in      : parallel word (DATA_W bits)
//   load_in      : producer requests transmission
//   ack_out      : 1-cycle pulse when data_in is captured
//   status_out   : high when IDLE and able to accept
//   status_in    : receiver ready
//   data_out     : serial bit, LSB first
//   write_out    : data_out valid for receiver
module serializador #(
  parameter int DATA_W = 8
) (
  input  logic              clock_100KHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load_in,
  output logic              ack_out,
  output logic              status_out,
  input  logic              status_in,
  output logic              data_out,
  output logic              write_out
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);

`ifdef SERIALIZADOR_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE   = 2'd2,
    PARITY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t state, state_nx;

  logic [CW-1:0]     cnt, cnt_nx;
  logic [DATA_W-1:0] sreg, sreg_nx;
  logic ack_nx, stat_nx, dout_nx, wr_nx;
  logic accept;

`ifdef SERIALIZADOR_PARITY_EN
  logic par, par_nx;
`endif

  assign accept = load_in & status_in;

  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      ack_out    <= 1'b0;
      status_out <= 1'b0;
      data_out   <= 1'b0;
      write_out  <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sreg       <= sreg_nx;
      ack_out    <= ack_nx;
      status_out <= stat_nx;
      data_out   <= dout_nx;
      write_out  <= wr_nx;
`ifdef SERIALIZADOR_PARITY_EN
      par        <= par_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (accept) state_nx = SHIFT;
      SHIFT:
        if (cnt == LAST) begin
`ifdef SERIALIZADOR_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = DONE;
`endif
        end
`ifdef SERIALIZADOR_PARITY_EN
      PARITY:
        state_nx = DONE;
`endif
      DONE:
        if (status_in) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // Bit 0 goes out on the capture edge, so the register keeps
  // the remaining bits pre-shifted; sreg[0] is always the next bit.
  always_comb begin
    cnt_nx  = cnt;
    sreg_nx = sreg;
    ack_nx  = 1'b0;
    stat_nx = 1'b0;
    dout_nx = 1'b0;
    wr_nx   = 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
    par_nx  = par;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_nx = data_in >> 1;
          dout_nx = data_in[0];
          wr_nx   = 1'b1;
          ack_nx  = 1'b1;
          cnt_nx  = CW'(1);
`ifdef SERIALIZADOR_PARITY_EN
          par_nx  = ^data_in;
`endif
        end else begin
          stat_nx = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          dout_nx = sreg[0];
          sreg_nx = sreg >> 1;
          wr_nx   = 1'b1;
          cnt_nx  = cnt + CW'(1);
        end else begin
          cnt_nx  = '0;
`ifdef SERIALIZADOR_PARITY_EN
          dout_nx = par;
          wr_nx   = 1'b1;
`endif
        end
      end
      DONE: begin
        if (status_in) stat_nx = 1'b1;
      end
      default: begin
        cnt_nx = cnt;
      end
    endcase
  end

endmodule

// File: tb/tb_serializador.sv
// Directed self-checking bench for serializador.
// Parity scenario is built only with SERIALIZADOR_PARITY_EN.
module tb_serializador;

`ifdef SERIALIZADOR_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif
  localparam int PER = FLEN + 2;

  logic       clock_100KHz;
  logic       reset;
  logic [7:0] data_in;
  logic       load_in;
  logic       ack_out;
  logic       status_out;
  logic       status_in;
  logic       data_out;
  logic       write_out;

  int checks;
  int failures;

  logic [63:0] r_ack, r_wr, r_dout, r_st;
  int idx;

  serializador #(.DATA_W(8)) dut (
    .clock_100KHz(clock_100KHz),
    .reset(reset),
    .data_in(data_in),
    .load_in(load_in),
    .ack_out(ack_out),
    .status_out(status_out),
    .status_in(status_in),
    .data_out(data_out),
    .write_out(write_out)
  );

  initial clock_100KHz = 1'b0;
  always #5 clock_100KHz = ~clock_100KHz;

  task automatic clear();
    r_ack  = '0;
    r_wr   = '0;
    r_dout = '0;
    r_st   = '0;
    idx    = 0;
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock_100KHz);
      if (idx < 64) begin
        r_ack[idx]  = ack_out;
        r_wr[idx]   = write_out;
        r_dout[idx] = data_out;
        r_st[idx]   = status_out;
      end
      idx++;
    end
  endtask

  function automatic logic [63:0] wr_mask(input int start);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < FLEN; i++) m[start+i] = 1'b1;
    return m;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    load_in = 1'b0;
    status_in = 1'b0;
    data_in = 8'h00;
    repeat (2) @(negedge clock_100KHz);
    checks++;
    if (ack_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_ack got %b exp 0", ack_out);
    end
    checks++;
    if (write_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_wr got %b exp 0", write_out);
    end
    checks++;
    if (data_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_dout got %b exp 0", data_out);
    end
    checks++;
    if (status_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_status got %b exp 0", status_out);
    end
    reset = 1'b1;
    @(negedge clock_100KHz);
    checks++;
    if (status_out !== 1'b1) begin
      failures++;
      $display("FAIL rst_release_status got %b exp 1", status_out);
    end
  endtask

  task automatic test_basic();
    logic [63:0] m;
    logic [11:0] st_exp;
    clear();
    data_in = 8'hA5;
    status_in = 1'b1;
    load_in = 1'b1;
    record(1);
    load_in = 1'b0;
    record(11);
    m = wr_mask(0);
    st_exp = ~((12'h1 << (FLEN + 1)) - 12'h1);
    checks++;
    if (r_ack !== 64'h1) begin
      failures++;
      $display("FAIL basic_ack got %h exp %h", r_ack, 64'h1);
    end
    checks++;
    if (r_wr !== m) begin
      failures++;
      $display("FAIL basic_wr got %h exp %h", r_wr, m);
    end
    checks++;
    if (r_dout !== 64'hA5) begin
      failures++;
      $display("FAIL basic_dout got %h exp %h", r_dout, 64'hA5);
    end
    checks++;
    if (r_st[11:0] !== st_exp) begin
      failures++;
      $display("FAIL basic_status got %h exp %h", r_st[11:0], st_exp);
    end
  endtask

  task automatic test_busy();
    logic [63:0] m;
    logic [63:0] d;
    clear();
    status_in = 1'b0;
    load_in = 1'b1;
    data_in = 8'h3C;
    record(5);
    status_in = 1'b1;
    record(1);
    load_in = 1'b0;
    record(11);
    m = wr_mask(5);
    d = 64'h3C << 5;
    checks++;
    if (r_ack !== 64'h20) begin
      failures++;
      $display("FAIL busy_ack got %h exp %h", r_ack, 64'h20);
    end
    checks++;
    if (r_wr !== m) begin
      failures++;
      $display("FAIL busy_wr got %h exp %h", r_wr, m);
    end
    checks++;
    if (r_dout !== d) begin
      failures++;
      $display("FAIL busy_dout got %h exp %h", r_dout, d);
    end
    checks++;
    if (r_st[4:0] !== 5'h1F) begin
      failures++;
      $display("FAIL busy_status got %h exp 1f", r_st[4:0]);
    end
  endtask

  task automatic test_load_busy();
    logic [63:0] m;
    logic [63:0] a;
    clear();
    status_in = 1'b1;
    data_in = 8'hFF;
    load_in = 1'b1;
    record(1);
    data_in = 8'h00;
    record(11);
    load_in = 1'b0;
    record(12);
    m = wr_mask(0) | wr_mask(PER);
    a = 64'h1 | (64'h1 << PER);
    checks++;
    if (r_ack !== a) begin
      failures++;
      $display("FAIL ldbusy_ack got %h exp %h", r_ack, a);
    end
    checks++;
    if (r_wr !== m) begin
      failures++;
      $display("FAIL ldbusy_wr got %h exp %h", r_wr, m);
    end
    checks++;
    if (r_dout !== 64'hFF) begin
      failures++;
      $display("FAIL ldbusy_dout got %h exp %h", r_dout, 64'hFF);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] m;
    status_in = 1'b1;
    load_in = 1'b0;
    repeat (3) @(negedge clock_100KHz);
    clear();
    data_in = 8'h81;
    load_in = 1'b1;
    record(1);
    load_in = 1'b0;
    record(3);
    checks++;
    if (r_wr[3:0] !== 4'hF || r_dout[3:0] !== 4'h1) begin
      failures++;
      $display("FAIL rmid_pre got wr=%h dout=%h exp f 1",
               r_wr[3:0], r_dout[3:0]);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (write_out !== 1'b0) begin
      failures++;
      $display("FAIL rmid_wr got %b exp 0", write_out);
    end
    checks++;
    if (data_out !== 1'b0 || ack_out !== 1'b0) begin
      failures++;
      $display("FAIL rmid_dout_ack got %b%b exp 00", data_out, ack_out);
    end
    @(negedge clock_100KHz);
    checks++;
    if (status_out !== 1'b0) begin
      failures++;
      $display("FAIL rmid_status_low got %b exp 0", status_out);
    end
    reset = 1'b1;
    clear();
    record(1);
    data_in = 8'h81;
    load_in = 1'b1;
    record(1);
    load_in = 1'b0;
    record(11);
    m = wr_mask(1);
    checks++;
    if (r_st[0] !== 1'b1 || r_ack !== 64'h2) begin
      failures++;
      $display("FAIL rmid_restart got st=%b ack=%h exp 1 2",
               r_st[0], r_ack);
    end
    checks++;
    if (r_dout !== (64'h81 << 1) || r_wr !== m) begin
      failures++;
      $display("FAIL rmid_frame got dout=%h wr=%h exp %h %h",
               r_dout, r_wr, 64'h81 << 1, m);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] m;
    logic [63:0] a;
    logic [63:0] d;
    status_in = 1'b1;
    load_in = 1'b0;
    repeat (3) @(negedge clock_100KHz);
    clear();
    data_in = 8'h55;
    load_in = 1'b1;
    record(3 * PER);
    load_in = 1'b0;
    m = wr_mask(0) | wr_mask(PER) | wr_mask(2 * PER);
    a = 64'h1 | (64'h1 << PER) | (64'h1 << (2 * PER));
    d = 64'h55 | (64'h55 << PER) | (64'h55 << (2 * PER));
    checks++;
    if (r_ack !== a) begin
      failures++;
      $display("FAIL b2b_ack got %h exp %h", r_ack, a);
    end
    checks++;
    if (r_wr !== m) begin
      failures++;
      $display("FAIL b2b_wr got %h exp %h", r_wr, m);
    end
    checks++;
    if (r_dout !== d) begin
      failures++;
      $display("FAIL b2b_dout got %h exp %h", r_dout, d);
    end
    record(PER + 2);
  endtask

`ifdef SERIALIZADOR_PARITY_EN
  task automatic test_parity();
    logic [63:0] m;
    logic [63:0] d;
    clear();
    status_in = 1'b1;
    data_in = 8'h07;
    load_in = 1'b1;
    record(1);
    data_in = 8'h03;
    record(PER);
    load_in = 1'b0;
    record(PER + 1);
    m = wr_mask(0) | wr_mask(PER);
    d = 64'h107 | (64'h03 << PER);
    checks++;
    if (r_wr !== m) begin
      failures++;
      $display("FAIL par_wr got %h exp %h", r_wr, m);
    end
    checks++;
    if (r_dout !== d) begin
      failures++;
      $display("FAIL par_dout got %h exp %h", r_dout, d);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    clear();
    test_reset();
    test_basic();
    test_busy();
    test_load_busy();
    test_back_to_back();
`ifdef SERIALIZADOR_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without completion");
    $fatal(1, "timeout");
  end

endmodule
